// File: rtl/snax_exercise_dotprod_acc_pkg.sv
// Shared types and default widths for the SNAX exercise dot-product accumulator.
package snax_exercise_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } dp_state_e;

  localparam int unsigned DefDataWidth    = 16;
  localparam int unsigned DefSpatPar      = 8;
  localparam int unsigned DefRegDataWidth = 32;
  localparam int unsigned DefAccWidth     = 48;

  // Width that holds the full sum of n values of in_w bits, signed or unsigned.
  function automatic int unsigned sum_width(input int unsigned in_w, input int unsigned n);
    return in_w + $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/snax_exercise_dotprod_acc_if.sv
// Operand and result streams of the dot-product accumulator.
// Handshake: a transfer happens on a rising edge where valid && ready; ready never depends on valid,
// and a producer holds data stable while valid is high and ready is low.
interface snax_exercise_dotprod_acc_if
  import snax_exercise_pkg::*;
#(
  parameter int unsigned DataWidth = DefDataWidth,
  parameter int unsigned SpatPar   = DefSpatPar,
  parameter int unsigned AccWidth  = DefAccWidth
);
  logic [SpatPar*DataWidth-1:0] a_i;
  logic [SpatPar*DataWidth-1:0] b_i;
  logic                         a_valid_i;
  logic                         b_valid_i;
  logic                         a_ready_o;
  logic                         b_ready_o;
  logic [AccWidth-1:0]          out_o;
  logic                         out_valid_o;
  logic                         out_ready_i;

  modport master (
    output a_i, b_i, a_valid_i, b_valid_i, out_ready_i,
    input  a_ready_o, b_ready_o, out_o, out_valid_o
  );

  modport slave (
    input  a_i, b_i, a_valid_i, b_valid_i, out_ready_i,
    output a_ready_o, b_ready_o, out_o, out_valid_o
  );
endinterface

// File: rtl/snax_exercise_dotprod_acc_adder_tree.sv
// Balanced adder tree over registered lane products; leaves are extended per the operand mode.
module snax_exercise_adder_tree
  import snax_exercise_pkg::*;
#(
  parameter  int unsigned NumIn    = DefSpatPar,
  parameter  int unsigned InWidth  = 2 * DefDataWidth,
  localparam int unsigned OutWidth = sum_width(InWidth, NumIn)
) (
  input  logic                     signed_i,
  input  logic [NumIn*InWidth-1:0] in_i,
  output logic [OutWidth-1:0]      sum_o
);

  localparam int Depth  = $clog2(NumIn);
  localparam int Leaves = 1 << Depth;

  // Leaves past NumIn stay zero so the tree is always a full power of two.
  logic [OutWidth-1:0] node [Depth+1][Leaves];
  logic [InWidth-1:0]  lane;

  always_comb begin
    lane = '0;
    for (int l = 0; l <= Depth; l++) begin
      for (int j = 0; j < Leaves; j++) begin
        node[l][j] = '0;
      end
    end
    for (int j = 0; j < int'(NumIn); j++) begin
      lane = in_i[j*InWidth +: InWidth];
      if (signed_i) node[0][j] = OutWidth'($signed(lane));
      else          node[0][j] = OutWidth'(lane);
    end
    for (int l = 1; l <= Depth; l++) begin
      for (int j = 0; j < (Leaves >> l); j++) begin
        node[l][j] = node[l-1][2*j] + node[l-1][2*j+1];
      end
    end
  end

  assign sum_o = node[Depth][0];

endmodule

// File: rtl/snax_exercise_dotprod_acc.sv
// Pipelined dot-product accumulator: product register, adder tree, accumulate, single result.
// Optional SNAX_EXERCISE_SATURATE_EN clamps the accumulator instead of wrapping.
module snax_exercise_dotprod_acc
  import snax_exercise_pkg::*;
#(
  parameter int unsigned DataWidth    = DefDataWidth,
  parameter int unsigned SpatPar      = DefSpatPar,
  parameter int unsigned RegDataWidth = DefRegDataWidth,
  parameter int unsigned AccWidth     = DefAccWidth
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [RegDataWidth-1:0] acc_len_i,
  input  logic [RegDataWidth-1:0] bias_i,
  input  logic                    signed_i,
  output logic                    busy_o,
  output logic                    sat_o,
  output dp_state_e               state_o,
  snax_exercise_dotprod_acc_if.slave strm
);

  localparam int unsigned ProdWidth = 2 * DataWidth;
  localparam int unsigned SumWidth  = sum_width(ProdWidth, SpatPar);

  if (SpatPar < 1 || AccWidth < SumWidth || AccWidth < RegDataWidth) begin : g_cfg_check
    $error("snax_exercise_dotprod_acc: AccWidth too narrow for DataWidth/SpatPar/RegDataWidth");
  end

  dp_state_e state_q, state_d;

  logic [RegDataWidth-1:0]      len_q, cnt_q;
  logic                         signed_q;
  logic [AccWidth-1:0]          acc_q, acc_next, bias_ext, sum_ext;
  logic [SpatPar*ProdWidth-1:0] prod_q, prod_d;
  logic                         s1_valid_q, s1_last_q;
  logic [ProdWidth-1:0]         a_ext, b_ext;
  logic [SumWidth-1:0]          tree_sum;
  logic                         beat_ready, accept, start_take;

  assign beat_ready = (state_q == RUN) && (cnt_q < len_q);
  assign accept     = beat_ready && strm.a_valid_i && strm.b_valid_i;
  assign start_take = (state_q == IDLE) && start_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = RUN;
      RUN:     if (s1_valid_q && s1_last_q) state_d = DONE;
      DONE:    if (strm.out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operands are widened to the product width first so one multiplier serves both modes.
  always_comb begin
    prod_d = '0;
    a_ext  = '0;
    b_ext  = '0;
    for (int i = 0; i < int'(SpatPar); i++) begin
      if (signed_q) begin
        a_ext = ProdWidth'($signed(strm.a_i[i*DataWidth +: DataWidth]));
        b_ext = ProdWidth'($signed(strm.b_i[i*DataWidth +: DataWidth]));
      end else begin
        a_ext = ProdWidth'(strm.a_i[i*DataWidth +: DataWidth]);
        b_ext = ProdWidth'(strm.b_i[i*DataWidth +: DataWidth]);
      end
      prod_d[i*ProdWidth +: ProdWidth] = a_ext * b_ext;
    end
  end

  snax_exercise_adder_tree #(
    .NumIn   (SpatPar),
    .InWidth (ProdWidth)
  ) u_adder_tree (
    .signed_i (signed_q),
    .in_i     (prod_q),
    .sum_o    (tree_sum)
  );

  always_comb begin
    if (signed_i) bias_ext = AccWidth'($signed(bias_i));
    else          bias_ext = AccWidth'(bias_i);
    if (signed_q) sum_ext = AccWidth'($signed(tree_sum));
    else          sum_ext = AccWidth'(tree_sum);
  end

`ifdef SNAX_EXERCISE_SATURATE_EN
  localparam int unsigned WideWidth = AccWidth + 1;

  logic [AccWidth:0] acc_wide, sum_wide, total;
  logic              ovf, sat_q;

  // One guard bit exposes signed overflow (top two bits differ) or unsigned carry-out.
  always_comb begin
    if (signed_q) begin
      acc_wide = WideWidth'($signed(acc_q));
      sum_wide = WideWidth'($signed(sum_ext));
    end else begin
      acc_wide = WideWidth'(acc_q);
      sum_wide = WideWidth'(sum_ext);
    end
    total    = acc_wide + sum_wide;
    ovf      = 1'b0;
    acc_next = total[AccWidth-1:0];
    if (signed_q) begin
      if (total[AccWidth] != total[AccWidth-1]) begin
        ovf      = 1'b1;
        acc_next = total[AccWidth] ? {1'b1, {(AccWidth-1){1'b0}}} : {1'b0, {(AccWidth-1){1'b1}}};
      end
    end else if (total[AccWidth]) begin
      ovf      = 1'b1;
      acc_next = '1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)           sat_q <= 1'b0;
    else if (start_take) sat_q <= 1'b0;
    else if (s1_valid_q) sat_q <= sat_q | ovf;
  end

  assign sat_o = sat_q;
`else
  assign acc_next = acc_q + sum_ext;
  assign sat_o    = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      len_q      <= '0;
      cnt_q      <= '0;
      signed_q   <= 1'b0;
      acc_q      <= '0;
      prod_q     <= '0;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        prod_q    <= prod_d;
        s1_last_q <= (cnt_q == len_q - RegDataWidth'(1));
        cnt_q     <= cnt_q + RegDataWidth'(1);
      end
      if (start_take) begin
        len_q    <= (acc_len_i == '0) ? RegDataWidth'(1) : acc_len_i;
        signed_q <= signed_i;
        acc_q    <= bias_ext;
        cnt_q    <= '0;
      end else if (s1_valid_q) begin
        acc_q <= acc_next;
      end
    end
  end

  assign strm.a_ready_o   = beat_ready;
  assign strm.b_ready_o   = beat_ready;
  assign strm.out_valid_o = (state_q == DONE);
  assign strm.out_o       = acc_q;
  assign busy_o           = (state_q != IDLE);
  assign state_o          = state_q;

endmodule

// File: tb/tb_snax_exercise_dotprod_acc.sv
// Directed bench for snax_exercise_dotprod_acc (AccWidth=36 so the overflow case is reachable).
module tb_snax_exercise_dotprod_acc;
  import snax_exercise_pkg::*;

  localparam int DW = 16;
  localparam int SP = 8;
  localparam int RW = 32;
  localparam int AW = 36;

  logic          clk = 1'b0;
  logic          rst_i, start_i, signed_i;
  logic [RW-1:0] acc_len_i, bias_i;
  logic          busy_o, sat_o;
  dp_state_e     state_o;

  int checks = 0;
  int errors = 0;
  logic [AW-1:0] exp_q[$];

  snax_exercise_dotprod_acc_if #(.DataWidth(DW), .SpatPar(SP), .AccWidth(AW)) strm ();

  snax_exercise_dotprod_acc #(
    .DataWidth(DW), .SpatPar(SP), .RegDataWidth(RW), .AccWidth(AW)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .acc_len_i(acc_len_i), .bias_i(bias_i),
    .signed_i(signed_i), .busy_o(busy_o), .sat_o(sat_o), .state_o(state_o), .strm(strm)
  );

  always #5 clk = ~clk;

  function automatic logic [SP*DW-1:0] fill(input logic [DW-1:0] v);
    logic [SP*DW-1:0] r;
    for (int i = 0; i < SP; i++) r[i*DW +: DW] = v;
    return r;
  endfunction

  function automatic logic [AW-1:0] dot_u(input logic [SP*DW-1:0] a, input logic [SP*DW-1:0] b);
    logic [AW-1:0] s = '0;
    for (int i = 0; i < SP; i++) s += AW'(a[i*DW +: DW]) * AW'(b[i*DW +: DW]);
    return s;
  endfunction

  // Drivers: all run in the phase 1 time unit after a rising edge.
  task automatic do_start(input logic [RW-1:0] len, input logic sgn, input logic [RW-1:0] bias);
    start_i = 1'b1; acc_len_i = len; signed_i = sgn; bias_i = bias;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic send_beat(input logic [SP*DW-1:0] a, input logic [SP*DW-1:0] b);
    int n = 0;
    strm.a_i = a; strm.b_i = b; strm.a_valid_i = 1'b1; strm.b_valid_i = 1'b1;
    while (strm.a_ready_o !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    checks++;
    if (n >= 50) begin errors++; $display("FAIL beat_timeout: ready=%b required 1", strm.a_ready_o); end
    @(posedge clk); #1;
    strm.a_valid_i = 1'b0; strm.b_valid_i = 1'b0;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (strm.out_valid_o !== 1'b1 && cyc < 100) begin @(posedge clk); #1; cyc++; end
    checks++;
    if (cyc >= 100) begin errors++; $display("FAIL out_timeout: out_valid=%b required 1", strm.out_valid_o); end
  endtask

  task automatic handshake();
    strm.out_ready_i = 1'b1;
    @(posedge clk); #1;
    strm.out_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; start_i = 1'b0; acc_len_i = '0; bias_i = '0; signed_i = 1'b0;
    strm.a_i = '0; strm.b_i = '0; strm.a_valid_i = 1'b0; strm.b_valid_i = 1'b0; strm.out_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(posedge clk); #1;
    checks++; if (strm.a_ready_o !== 1'b0 || strm.b_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: a=%b b=%b required 0", strm.a_ready_o, strm.b_ready_o); end
    checks++; if (strm.out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", strm.out_valid_o); end
    checks++; if (busy_o !== 1'b0 || sat_o !== 1'b0) begin errors++; $display("FAIL reset_busy_sat: busy=%b sat=%b required 0", busy_o, sat_o); end
    checks++; if (strm.out_o !== '0) begin errors++; $display("FAIL reset_out: got %h required 0", strm.out_o); end
    checks++; if (state_o !== IDLE) begin errors++; $display("FAIL reset_state: got %0d required %0d", state_o, IDLE); end
  endtask

  task automatic test_unsigned_single();
    logic [SP*DW-1:0] a;
    int cyc;
    for (int i = 0; i < SP; i++) a[i*DW +: DW] = DW'(i + 1);
    exp_q.push_back(AW'(77));
    do_start(1, 1'b0, 5);
    checks++; if (busy_o !== 1'b1 || strm.a_ready_o !== 1'b1) begin errors++; $display("FAIL start_busy_ready: busy=%b ready=%b required 1", busy_o, strm.a_ready_o); end
    send_beat(a, fill(16'd2));
    checks++; if (strm.a_ready_o !== 1'b0) begin errors++; $display("FAIL ready_drop_single: got %b required 0", strm.a_ready_o); end
    wait_out(cyc);
    checks++; if (cyc != 1) begin errors++; $display("FAIL latency_single: got %0d extra cycles required 1", cyc); end
    checks++; if (strm.out_o !== exp_q[0]) begin errors++; $display("FAIL unsigned_single: got %0d required %0d", strm.out_o, exp_q[0]); end
    void'(exp_q.pop_front());
    handshake();
    checks++; if (strm.out_valid_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL after_handshake: valid=%b busy=%b required 0", strm.out_valid_o, busy_o); end
  endtask

  task automatic test_signed_multi();
    logic [AW-1:0] e;
    int cyc;
    e = -36'sd73;
    exp_q.push_back(e);
    do_start(3, 1'b1, 32'hFFFF_FFFF);
    for (int k = 0; k < 3; k++) send_beat(fill(16'hFFFF), fill(16'd3));
    wait_out(cyc);
    checks++; if (cyc != 1) begin errors++; $display("FAIL latency_multi: got %0d extra cycles required 1", cyc); end
    checks++; if (strm.out_o !== exp_q[0]) begin errors++; $display("FAIL signed_multi: got %h required %h", strm.out_o, exp_q[0]); end
    void'(exp_q.pop_front());
    handshake();
  endtask

  task automatic test_stalls();
    logic [SP*DW-1:0] a, b;
    logic [AW-1:0]    e;
    logic             av, bv;
    int               got, cyc;
    e = '0; got = 0; cyc = 0;
    do_start(16, 1'b0, 0);
    while (got < 16 && cyc < 400) begin
      av = 1'($urandom_range(0, 1)); bv = 1'($urandom_range(0, 1));
      for (int i = 0; i < SP; i++) begin
        a[i*DW +: DW] = DW'($urandom_range(0, 4095)); b[i*DW +: DW] = DW'($urandom_range(0, 4095));
      end
      strm.a_i = a; strm.b_i = b; strm.a_valid_i = av; strm.b_valid_i = bv;
      if (av && bv) begin e += dot_u(a, b); got++; end
      @(posedge clk); #1; cyc++;
    end
    strm.a_valid_i = 1'b0; strm.b_valid_i = 1'b0;
    checks++; if (got != 16) begin errors++; $display("FAIL stall_beats: got %0d required 16", got); end
    checks++; if (strm.a_ready_o !== 1'b0) begin errors++; $display("FAIL ready_drop_stall: got %b required 0", strm.a_ready_o); end
    exp_q.push_back(e);
    wait_out(cyc);
    checks++; if (strm.out_o !== exp_q[0]) begin errors++; $display("FAIL stall_result: got %h required %h", strm.out_o, exp_q[0]); end
    void'(exp_q.pop_front());
    handshake();
  endtask

  task automatic test_backpressure();
    int cyc;
    exp_q.push_back(AW'(180));
    do_start(1, 1'b0, 100);
    send_beat(fill(16'd2), fill(16'd5));
    wait_out(cyc);
    for (int k = 0; k < 5; k++) begin
      checks++; if (strm.out_o !== exp_q[0] || strm.out_valid_o !== 1'b1) begin errors++; $display("FAIL backpressure_hold: out=%0d valid=%b required %0d 1", strm.out_o, strm.out_valid_o, exp_q[0]); end
      checks++; if (strm.a_ready_o !== 1'b0 || busy_o !== 1'b1) begin errors++; $display("FAIL backpressure_flags: ready=%b busy=%b required 0 1", strm.a_ready_o, busy_o); end
      start_i = (k == 1); acc_len_i = 2; bias_i = 7;
      @(posedge clk); #1;
      start_i = 1'b0;
    end
    checks++; if (state_o !== DONE) begin errors++; $display("FAIL backpressure_state: got %0d required %0d", state_o, DONE); end
    void'(exp_q.pop_front());
    handshake();
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL backpressure_release: busy=%b required 0", busy_o); end
  endtask

  task automatic test_overflow();
    int cyc;
`ifdef SNAX_EXERCISE_SATURATE_EN
    exp_q.push_back(36'hF_FFFF_FFFF);
`else
    exp_q.push_back(36'hF_FFC0_0020);
`endif
    do_start(4, 1'b0, 0);
    for (int k = 0; k < 4; k++) send_beat(fill(16'hFFFF), fill(16'hFFFF));
    wait_out(cyc);
    checks++; if (strm.out_o !== exp_q[0]) begin errors++; $display("FAIL overflow_result: got %h required %h", strm.out_o, exp_q[0]); end
`ifdef SNAX_EXERCISE_SATURATE_EN
    checks++; if (sat_o !== 1'b1) begin errors++; $display("FAIL overflow_sat: got %b required 1", sat_o); end
`else
    checks++; if (sat_o !== 1'b0) begin errors++; $display("FAIL overflow_sat: got %b required 0", sat_o); end
`endif
    void'(exp_q.pop_front());
    handshake();
  endtask

  task automatic test_len_zero();
    int cyc;
    exp_q.push_back(AW'(8));
    do_start(0, 1'b0, 0);
    checks++; if (sat_o !== 1'b0) begin errors++; $display("FAIL sat_clear_on_start: got %b required 0", sat_o); end
    send_beat(fill(16'd1), fill(16'd1));
    checks++; if (strm.a_ready_o !== 1'b0) begin errors++; $display("FAIL len_zero_ready: got %b required 0", strm.a_ready_o); end
    wait_out(cyc);
    checks++; if (strm.out_o !== exp_q[0]) begin errors++; $display("FAIL len_zero_result: got %0d required %0d", strm.out_o, exp_q[0]); end
    void'(exp_q.pop_front());
    handshake();
  endtask

  task automatic test_reset_mid_job();
    logic [AW-1:0] e;
    int cyc;
    do_start(4, 1'b0, 9);
    for (int k = 0; k < 2; k++) send_beat(fill(16'd4), fill(16'd4));
    #2 rst_i = 1'b1;
    #1;
    checks++; if (busy_o !== 1'b0 || strm.a_ready_o !== 1'b0 || strm.out_valid_o !== 1'b0) begin errors++; $display("FAIL async_reset_flags: busy=%b ready=%b valid=%b required 0", busy_o, strm.a_ready_o, strm.out_valid_o); end
    checks++; if (strm.out_o !== '0 || sat_o !== 1'b0) begin errors++; $display("FAIL async_reset_out: out=%h sat=%b required 0", strm.out_o, sat_o); end
    @(posedge clk); #1 rst_i = 1'b0;
    e = -36'sd38;
    exp_q.push_back(e);
    do_start(1, 1'b1, 10);
    send_beat(fill(16'd3), fill(16'hFFFE));
    wait_out(cyc);
    checks++; if (cyc != 1) begin errors++; $display("FAIL latency_after_reset: got %0d extra cycles required 1", cyc); end
    checks++; if (strm.out_o !== exp_q[0]) begin errors++; $display("FAIL fresh_job_result: got %h required %h", strm.out_o, exp_q[0]); end
    void'(exp_q.pop_front());
    handshake();
  endtask

  initial begin
    test_reset();
    test_unsigned_single();
    test_signed_multi();
    test_stalls();
    test_backpressure();
    test_overflow();
    test_len_zero();
    test_reset_mid_job();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
